// File: rtl/trace_pkg.sv
// Shared definitions for the retirement-trace recorder: FSM state encoding,
// record field widths and the default cycle budget.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int WE_W    = 1;
  localparam int WADDR_W = 5;
  localparam int WDATA_W = 32;

  // Everything in a record except the cycle stamp.
  localparam int PAYLOAD_W = PC_W + INST_W + WE_W + WADDR_W + WDATA_W;

  localparam int unsigned MAX_CYCLES_DEF = 32'h0000_0230;

  // Packed record width: {cycle, pc, inst, we, waddr, wdata}.
  function automatic int rec_width(input int cnt_w);
    return cnt_w + PAYLOAD_W;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with first-word-fall-through head output. Pointers carry
// one extra wrap bit so full and empty are distinguishable without a counter.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointer update; reset and clear empty the FIFO, storage is left as is.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; a push into a full FIFO with a same-cycle pop reuses the
  // slot whose old contents are being consumed at this edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/trace_recorder.sv
// Retirement-trace capture unit: stamps each retired instruction with the
// run cycle count, buffers it in a FIFO and drains it over valid/ready.
// Optional macro TRACE_FILTER_EN restricts capture to visible register writes
// (rf_we with a non-zero destination).
module trace_recorder
  import trace_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int          DROP_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              retire_valid,
  input  logic [31:0]       retire_pc,
  input  logic [31:0]       retire_inst,
  input  logic              rf_we,
  input  logic [4:0]        rf_waddr,
  input  logic [31:0]       rf_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_cycle,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic              out_we,
  output logic [4:0]        out_waddr,
  output logic [31:0]       out_wdata,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy,
  output logic              done
);

  localparam int               REC_W      = rec_width(CNT_W);
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             capture;
  logic             push;
  logic             pop;
  logic             drop;
  logic             start_run;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_head;
  logic [REC_W-1:0] rec_vis;

`ifdef TRACE_FILTER_EN
  assign capture = (state == RUN) && retire_valid && rf_we && (rf_waddr != 5'd0);
`else
  assign capture = (state == RUN) && retire_valid;
`endif

  // A full FIFO still accepts a push when the consumer frees a slot this cycle.
  assign pop       = !fifo_empty && out_ready;
  assign push      = capture && (!fifo_full || pop);
  assign drop      = capture && fifo_full && !pop;
  assign start_run = ((state == IDLE) || (state == DONE)) && start;

  assign rec_in = {cycle_cnt, retire_pc, retire_inst, rf_we, rf_waddr, rf_wdata};

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_run),
    .push  (push),
    .din   (rec_in),
    .pop   (pop),
    .head  (rec_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: stop and budget end RUN; start is only honoured when idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (stop || (cycle_cnt == LAST_CYCLE)) state_nxt = DRAIN;
      DRAIN:      if (fifo_empty) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Cycle counter: cleared on a new run, advances every RUN cycle, wraps.
  always_ff @(posedge clk) begin
    if (rst || start_run)  cycle_cnt <= '0;
    else if (state == RUN) cycle_cnt <= cycle_cnt + CNT_W'(1);
  end

  // Drop counter: counts captures lost to a full FIFO, saturating.
  always_ff @(posedge clk) begin
    if (rst || start_run)            drop_cnt <= '0;
    else if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
  end

  // Data outputs read as zero whenever nothing is buffered.
  assign rec_vis   = fifo_empty ? '0 : rec_head;
  assign out_valid = !fifo_empty;
  assign {out_cycle, out_pc, out_inst, out_we, out_waddr, out_wdata} = rec_vis;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_trace_recorder.sv
// Bench for trace_recorder (DEPTH=4, MAX_CYCLES=8): hand-derived vector table,
// directed multi-cycle sequences and randomized runs against a queue model.
module tb_trace_recorder;

  localparam int DEPTH_T = 4;
  localparam int MAX_T   = 8;

  logic        clk = 1'b0;
  logic        rst, start, stop, retire_valid, rf_we, out_ready;
  logic [31:0] retire_pc, retire_inst, rf_wdata;
  logic [4:0]  rf_waddr;
  logic        out_valid, out_we, busy, done;
  logic [31:0] out_cycle, out_pc, out_inst, out_wdata, cycle_cnt;
  logic [4:0]  out_waddr;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  trace_recorder #(
    .DEPTH(DEPTH_T), .CNT_W(32), .MAX_CYCLES(MAX_T), .DROP_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_inst(retire_inst),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_cycle(out_cycle),
    .out_pc(out_pc), .out_inst(out_inst), .out_we(out_we), .out_waddr(out_waddr),
    .out_wdata(out_wdata), .cycle_cnt(cycle_cnt), .drop_cnt(drop_cnt),
    .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
  int          m_mode = M_IDLE;
  logic [31:0] m_cnt  = '0;
  logic [15:0] m_drop = '0;
  rec_t        mq[$];

  task automatic model_step();
    int   sz0;
    bit   pop, cap;
    rec_t r;
    sz0 = mq.size();
    pop = (sz0 > 0) && out_ready;
    if (rst) begin
      m_mode = M_IDLE; m_cnt = '0; m_drop = '0; mq.delete();
      return;
    end
    if (pop) void'(mq.pop_front());
    case (m_mode)
      M_IDLE, M_DONE: if (start) begin
        m_mode = M_RUN; m_cnt = '0; m_drop = '0; mq.delete();
      end
      M_RUN: begin
`ifdef TRACE_FILTER_EN
        cap = retire_valid && rf_we && (rf_waddr != 5'd0);
`else
        cap = retire_valid;
`endif
        if (cap) begin
          if (sz0 < DEPTH_T || pop) begin
            r = '{m_cnt, retire_pc, retire_inst, rf_we, rf_waddr, rf_wdata};
            mq.push_back(r);
          end else if (m_drop != 16'hFFFF) begin
            m_drop = m_drop + 16'd1;
          end
        end
        if (stop || m_cnt == 32'(MAX_T - 1)) m_mode = M_DRAIN;
        m_cnt = m_cnt + 32'd1;
      end
      default: if (sz0 == 0) m_mode = M_DONE;
    endcase
  endtask

  function automatic logic [255:0] model_vec();
    rec_t h;
    bit   v;
    v = (mq.size() > 0);
    h = '{32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
    if (v) h = mq[0];
    return 256'({v, h.cyc, h.pc, h.inst, h.we, h.waddr, h.wdata, m_cnt, m_drop,
                 (m_mode == M_RUN || m_mode == M_DRAIN), (m_mode == M_DONE)});
  endfunction

  function automatic logic [255:0] dut_vec();
    return 256'({out_valid, out_cycle, out_pc, out_inst, out_we, out_waddr, out_wdata,
                 cycle_cnt, drop_cnt, busy, done});
  endfunction

  // One clock: advance the model alongside the DUT and compare everything.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic set_in(input bit st, input bit sp, input bit rv,
                        input logic [31:0] pc, input bit rdy);
    rst = 1'b0; start = st; stop = sp; retire_valid = rv; out_ready = rdy;
    retire_pc = pc; retire_inst = ~pc; rf_we = 1'b1;
    rf_waddr = {1'b0, pc[5:2]} + 5'd1; rf_wdata = pc ^ 32'h5A5A_0F0F;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 32'd0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          st, sp, rv;
    logic [31:0] pc;
    bit          rdy;
    bit          e_valid;
    logic [31:0] e_cycle, e_pc, e_cnt;
    bit          e_busy, e_done;
  } vec_t;

  vec_t tbl[6];

  logic [31:0] last_stamp;

  initial begin
    tbl[0] = '{1, 0, 0, 32'h0,        1, 0, 32'd0, 32'h0,        32'd0, 1, 0};
    tbl[1] = '{0, 0, 1, 32'h00400000, 1, 1, 32'd0, 32'h00400000, 32'd1, 1, 0};
    tbl[2] = '{0, 0, 1, 32'h00400004, 1, 1, 32'd1, 32'h00400004, 32'd2, 1, 0};
    tbl[3] = '{0, 0, 1, 32'h00400008, 1, 1, 32'd2, 32'h00400008, 32'd3, 1, 0};
    tbl[4] = '{0, 1, 0, 32'h0,        1, 0, 32'd0, 32'h0,        32'd4, 1, 0};
    tbl[5] = '{0, 0, 0, 32'h0,        1, 0, 32'd0, 32'h0,        32'd4, 0, 1};

    // Reset state
    do_reset();
    check("reset_outputs", dut_vec(), 256'd0);

    // Three in-order retirements, then stop and drain
    for (int i = 0; i < 6; i++) begin
      set_in(tbl[i].st, tbl[i].sp, tbl[i].rv, tbl[i].pc, tbl[i].rdy);
      tick();
      check($sformatf("table%0d", i),
            256'({out_valid, out_cycle, out_pc, cycle_cnt, busy, done}),
            256'({tbl[i].e_valid, tbl[i].e_cycle, tbl[i].e_pc, tbl[i].e_cnt,
                  tbl[i].e_busy, tbl[i].e_done}));
    end

    // Overflow: 6 retirements into 4 slots with the consumer stalled
    do_reset();
    set_in(1, 0, 0, 32'd0, 0); tick();
    for (int i = 0; i < 6; i++) begin
      set_in(0, 0, 1, 32'h100 + 32'(4 * i), 0); tick();
    end
    check("overflow_drop", 256'(drop_cnt), 256'd2);
    set_in(0, 1, 0, 32'd0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("overflow_head%0d", i), 256'({out_valid, out_cycle, out_pc}),
            256'({1'b1, 32'(i), 32'h100 + 32'(4 * i)}));
      set_in(0, 0, 0, 32'd0, 1); tick();
    end
    check("overflow_empty", 256'(out_valid), 256'd0);
    tick();
    check("overflow_done", 256'(done), 256'd1);

    // Budget: continuous retirements with MAX_CYCLES=8
    do_reset();
    set_in(1, 0, 0, 32'd0, 1); tick();
    last_stamp = 32'hFFFF_FFFF;
    for (int i = 0; i < 14; i++) begin
      set_in(0, 0, 1, 32'h200 + 32'(4 * i), 1); tick();
      if (out_valid) last_stamp = out_cycle;
    end
    check("budget_last_stamp", 256'(last_stamp), 256'd7);
    check("budget_cnt_done", 256'({cycle_cnt, done}), 256'({32'd8, 1'b1}));

    // Stop with two entries buffered and the consumer stalled
    do_reset();
    set_in(1, 0, 0, 32'd0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, (i < 2), 32'h300 + 32'(4 * i), 0); tick();
    end
    set_in(0, 1, 0, 32'd0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 1, 32'h380 + 32'(4 * i), 0); tick();
    end
    check("stop_hold", 256'({busy, out_valid, out_cycle, drop_cnt, cycle_cnt}),
          256'({1'b1, 1'b1, 32'd0, 16'd0, 32'd6}));
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 32'd0, 1); tick();
    end
    check("stop_drained", 256'({out_valid, busy, done}), 256'({1'b0, 1'b0, 1'b1}));

    // Push into a full FIFO while popping, then reset mid-run
    do_reset();
    set_in(1, 0, 0, 32'd0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 1, 32'h400 + 32'(4 * i), 0); tick();
    end
    set_in(0, 0, 1, 32'h410, 1); tick();
    check("full_pushpop", 256'({drop_cnt, out_valid, out_cycle}),
          256'({16'd0, 1'b1, 32'd1}));
    set_in(0, 0, 1, 32'h414, 0); rst = 1'b1; tick();
    check("reset_midrun", 256'({out_valid, busy, done, cycle_cnt}), 256'd0);

    // Filter candidates: r0 write, no write, visible write
    do_reset();
    set_in(1, 0, 0, 32'd0, 0); tick();
    set_in(0, 0, 1, 32'h500, 0); rf_we = 1'b1; rf_waddr = 5'd0; tick();
    set_in(0, 0, 1, 32'h504, 0); rf_we = 1'b0; rf_waddr = 5'd5; tick();
    set_in(0, 0, 1, 32'h508, 0); rf_we = 1'b1; rf_waddr = 5'd8;
    rf_wdata = 32'h12345678; tick();
    set_in(0, 0, 0, 32'd0, 0); tick();
`ifdef TRACE_FILTER_EN
    check("filter_entry", 256'({out_valid, out_waddr, out_wdata}),
          256'({1'b1, 5'd8, 32'h12345678}));
    set_in(0, 0, 0, 32'd0, 1); tick();
    check("filter_single", 256'(out_valid), 256'd0);
`else
    check("nofilter_entry", 256'({out_valid, out_waddr, out_pc}),
          256'({1'b1, 5'd0, 32'h500}));
`endif

    // Randomized runs against the model
    for (int run = 0; run < 150; run++) begin
      if ($urandom % 4 == 0) do_reset();
      set_in(1, 0, 0, 32'd0, ($urandom % 2) == 1); tick();
      for (int c = 0; c < 20; c++) begin
        set_in(($urandom % 10) == 0, ($urandom % 16) == 0, ($urandom % 10) < 7,
               $urandom, ($urandom % 10) < 3);
        rf_we    = 1'($urandom % 2);
        rf_waddr = 5'($urandom % 4);
        rst      = (($urandom % 60) == 0);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trace_recorder.md
Name: trace_recorder

Overview:
- Synthesizable retirement-trace capture unit that sits beside the single-cycle MIPS core (sccomp_dataflow) in simulation and FPGA builds.
- Records one entry per retired instruction: cycle stamp, pc, inst and register-file write info.
- Buffers entries in a parametrised FIFO and drains them through a valid/ready port to a dumper or UART bridge.
- Replaces ad-hoc per-cycle testbench dumps. Adds a cycle budget, explicit stop and drain phases, and drop accounting.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, 32, width of the cycle counter and the cycle stamp.
- MAX_CYCLES, 32'h0000_0230, cycle budget; RUN ends automatically when the counter reaches MAX_CYCLES-1.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; IDLE/DONE -> RUN
- stop  in  1  pulse; RUN -> DRAIN
- retire_valid  in  1  an instruction retires this cycle
- retire_pc  in  32  pc of the retiring instruction
- retire_inst  in  32  instruction word
- rf_we  in  1  register-file write enable
- rf_waddr  in  5  destination register
- rf_wdata  in  32  write data
- out_valid  out  1  entry available
- out_ready  in  1  consumer accepts
- out_cycle  out  CNT_W  cycle stamp of the entry
- out_pc  out  32  recorded pc
- out_inst  out  32  recorded inst
- out_we  out  1  recorded write enable
- out_waddr  out  5  recorded destination
- out_wdata  out  32  recorded write data
- cycle_cnt  out  CNT_W  current cycle count
- drop_cnt  out  DROP_W  entries lost because the FIFO was full
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE

Behaviour:
- One clock domain. Reset is synchronous: on rst=1 at a posedge, state=IDLE and all outputs are 0 (out_valid, cycle_cnt, drop_cnt, busy, done, all out_* data). FIFO pointers are cleared.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN, clearing cycle_cnt, drop_cnt and the FIFO.
  - RUN: cycle_cnt increments every cycle, wrapping modulo 2^CNT_W. Go to DRAIN if stop=1 or cycle_cnt==MAX_CYCLES-1; the capture in that same cycle is still taken.
  - DRAIN: no captures; cycle_cnt holds; go to DONE when the FIFO is empty.
  - DONE: done=1; start -> RUN with the same clears as from IDLE.
- Priority: rst > stop > budget > start. start while in RUN or DRAIN is ignored.
- Capture (RUN only):
  - Capture when retire_valid=1.
  - The entry stamp is the cycle_cnt value before increment.
  - The entry is written at the clock edge and is visible on out_* no earlier than the next cycle.
- Full FIFO:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and drop_cnt increments, saturating at all-ones.
- Output handshake:
  - out_valid = FIFO not empty.
  - Pop occurs when out_valid && out_ready.
  - out_* hold stable while out_valid && !out_ready.
  - out_* show the head entry (first-word-fall-through).
- Simultaneous push and pop on an empty FIFO: the entry is stored; out_valid rises next cycle with no bypass.
- Draining continues in every state except under reset. Reset mid-RUN discards all buffered entries.

Optional Feature:
- Macro TRACE_FILTER_EN.
- When defined: capture only when retire_valid && rf_we && rf_waddr!=0, i.e. architecturally visible register writes. drop_cnt counts only filtered entries.
- When undefined: every retirement is captured.

Decomposition:
- Package trace_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3);
  - record field widths and the packed record width (CNT_W+32+32+1+5+32);
  - a default MAX_CYCLES constant.
- One sub-module, trace_fifo: parametrised synchronous FIFO with DEPTH and WIDTH, extra-bit pointers, full/empty flags and FWFT head output.
- The top holds the FSM, counters and filter.

Test Plan:
- Reset then start; 3 retirements (pc 0x00400000, 0x00400004, 0x00400008) at cycles 0, 1, 2; out_ready=1 -> 3 entries in order with out_cycle 0, 1, 2; done after drain.
- DEPTH=4, out_ready=0, 6 consecutive retirements -> 4 stored, drop_cnt=2; raise out_ready -> the 4 oldest entries emerge unchanged.
- MAX_CYCLES=8, continuous retirements -> the last entry has out_cycle=7; DRAIN then DONE; cycle_cnt holds at 8.
- stop pulse at cycle 5 with 2 entries buffered and out_ready=0 -> busy stays 1, no new captures; when out_ready=1 both entries drain and done=1.
- Full FIFO with push and pop in the same cycle -> push accepted, drop_cnt unchanged; rst mid-RUN -> out_valid=0, state IDLE next cycle.
- TRACE_FILTER_EN defined, retirements with (rf_we=1, waddr=0), (rf_we=0), (rf_we=1, waddr=8, wdata=0x12345678) -> exactly one entry: out_waddr=8, out_wdata=0x12345678.
